// File: rtl/idiv_unit.sv
// idiv_unit: iterative restoring radix-2 integer divider.
// Produces quotient and remainder for signed or unsigned operands, one
// quotient bit per cycle. Signed operation divides the operand magnitudes
// and re-applies the signs in a final fix-up cycle. Divide by zero
// short-circuits straight to the result cycle.
module idiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_is_signed,
   input  logic             i_flush,
   input  logic [WIDTH-1:0] i_numer,
   input  logic [WIDTH-1:0] i_denom,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder,
   output logic             o_div_by_zero
);

   // Counter must be able to represent WIDTH.
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_next;

   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_prem;      // partial remainder (always < divisor)
   logic [WIDTH-1:0] r_dvd;       // dividend magnitude; quotient bits shift in at LSB
   logic [WIDTH-1:0] r_dsr;       // divisor magnitude
   logic             r_q_neg;     // quotient must be negated in FIX
   logic             r_r_neg;     // remainder must be negated in FIX
   logic [WIDTH-1:0] r_quot;
   logic [WIDTH-1:0] r_rem_out;
   logic             r_dbz;

   logic             w_idle_or_done;
   logic             w_accept;
   logic             w_denom_zero;
   logic             w_numer_neg;
   logic             w_denom_neg;
   logic [WIDTH-1:0] w_numer_mag;
   logic [WIDTH-1:0] w_denom_mag;
   logic [WIDTH:0]   w_shift;     // shifted partial remainder, one bit wider
   logic [WIDTH-1:0] w_diff;
   logic             w_ge;
   logic             w_last;

   // Request acceptance: only when idle or presenting a result, never with flush.
   assign w_idle_or_done = (r_state == S_IDLE) || (r_state == S_DONE);
   assign w_accept       = w_idle_or_done && i_start && !i_flush;
   assign w_denom_zero   = (i_denom == '0);

   // Operand signs only matter for signed requests.
   assign w_numer_neg = i_is_signed && i_numer[WIDTH-1];
   assign w_denom_neg = i_is_signed && i_denom[WIDTH-1];
   // The most negative value maps onto itself, which as an unsigned magnitude
   // is still correct (2^(WIDTH-1)), so the overflow case needs no special path.
   assign w_numer_mag = w_numer_neg ? -i_numer : i_numer;
   assign w_denom_mag = w_denom_neg ? -i_denom : i_denom;

   // One restoring step: shift in the next dividend bit, trial-subtract.
   // When the trial succeeds the true difference is below 2^WIDTH, so the low
   // WIDTH bits of the modular subtraction are exact.
   assign w_shift = {r_prem, r_dvd[WIDTH-1]};
   assign w_ge    = (w_shift >= {1'b0, r_dsr});
   assign w_diff  = w_shift[WIDTH-1:0] - r_dsr;
   assign w_last  = (r_count == CW'(WIDTH - 1));

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; flush always wins and returns to IDLE.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_next = w_denom_zero ? S_DONE : S_CALC;
            end
         end
         S_CALC: begin
            if (i_flush) begin
               w_state_next = S_IDLE;
            end else if (w_last) begin
               w_state_next = S_FIX;
            end
         end
         S_FIX: begin
            w_state_next = i_flush ? S_IDLE : S_DONE;
         end
         S_DONE: begin
            if (w_accept) begin
               w_state_next = w_denom_zero ? S_DONE : S_CALC;
            end else begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Iteration datapath: operand capture on accept, one division step per CALC cycle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_count <= '0;
         r_prem  <= '0;
         r_dvd   <= '0;
         r_dsr   <= '0;
         r_q_neg <= 1'b0;
         r_r_neg <= 1'b0;
      end else if (w_accept) begin
         r_count <= '0;
         r_prem  <= '0;
         r_dvd   <= w_numer_mag;
         r_dsr   <= w_denom_mag;
         r_q_neg <= w_numer_neg ^ w_denom_neg;
         r_r_neg <= w_numer_neg;
      end else if ((r_state == S_CALC) && !i_flush) begin
         r_count <= r_count + CW'(1);
         r_prem  <= w_ge ? w_diff : w_shift[WIDTH-1:0];
         r_dvd   <= {r_dvd[WIDTH-2:0], w_ge};
      end
   end

   // Result registers: held between completions, untouched by flush.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_quot    <= '0;
         r_rem_out <= '0;
         r_dbz     <= 1'b0;
      end else if (w_accept) begin
         r_dbz <= w_denom_zero;
         if (w_denom_zero) begin
            r_quot    <= '1;
            r_rem_out <= i_numer;
         end
      end else if ((r_state == S_FIX) && !i_flush) begin
         r_quot    <= r_q_neg ? -r_dvd  : r_dvd;
         r_rem_out <= r_r_neg ? -r_prem : r_prem;
      end
   end

   assign o_busy        = (r_state == S_CALC) || (r_state == S_FIX);
   assign o_done        = (r_state == S_DONE);
   assign o_quotient    = r_quot;
   assign o_remainder   = r_rem_out;
   assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_idiv_unit.sv
// Testbench for idiv_unit: directed vector table plus hand-written
// sequences for busy-start, back-to-back, flush and asynchronous reset.
module tb_idiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        is_signed;
   logic        flush;
   logic [31:0] numer;
   logic [31:0] denom;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;

   int checks   = 0;
   int failures = 0;

   idiv_unit #(.WIDTH(32)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_start       (start),
      .i_is_signed   (is_signed),
      .i_flush       (flush),
      .i_numer       (numer),
      .i_denom       (denom),
      .o_busy        (busy),
      .o_done        (done),
      .o_quotient    (quotient),
      .o_remainder   (remainder),
      .o_div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] n;
      logic [31:0] d;
      logic        s;
      logic [31:0] q;
      logic [31:0] r;
      logic        z;
      int          cyc;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Present a request for one rising edge (the accept edge E0).
   task automatic start_op(input logic [31:0] n, input logic [31:0] d, input logic s);
      numer     = n;
      denom     = d;
      is_signed = s;
      start     = 1'b1;
      @(posedge clk);
      #1 start  = 1'b0;
   endtask

   // Count cycles after the accept edge until done, sampling on falling edges.
   task automatic wait_done(output int done_cyc, output int busy_cnt);
      done_cyc = 0;
      busy_cnt = 0;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (done) begin
            done_cyc = c;
            break;
         end
         if (busy) busy_cnt++;
      end
   endtask

   initial begin
      int dc;
      int bc;
      int done_seen;
      int busy_seen;

      //            numer         denom         s     quotient      remainder     z     cyc
      vecs[0] = '{32'd100,      32'd7,        1'b0, 32'd14,       32'd2,        1'b0, 34};
      vecs[1] = '{32'hFFFFFF9C, 32'd7,        1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 34};
      vecs[2] = '{32'd100,      32'hFFFFFFF9, 1'b1, 32'hFFFFFFF2, 32'd2,        1'b0, 34};
      vecs[3] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0,        1'b0, 34};
      vecs[4] = '{32'hFFFFFFFF, 32'd1,        1'b0, 32'hFFFFFFFF, 32'd0,        1'b0, 34};
      vecs[5] = '{32'h00001234, 32'd0,        1'b0, 32'hFFFFFFFF, 32'h00001234, 1'b1, 1};
      vecs[6] = '{32'd9,        32'd3,        1'b0, 32'd3,        32'd0,        1'b0, 34};
      vecs[7] = '{32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 32'd3,        32'hFFFFFFFF, 1'b0, 34};
      vecs[8] = '{32'hFFFFFFFF, 32'h00000010, 1'b0, 32'h0FFFFFFF, 32'h0000000F, 1'b0, 34};
      vecs[9] = '{32'hFFFFFFF9, 32'd0,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 1};

      rst       = 1'b1;
      start     = 1'b0;
      is_signed = 1'b0;
      flush     = 1'b0;
      numer     = '0;
      denom     = '0;
      #1;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_quotient", quotient, 32'd0);
      chk("reset_remainder", remainder, 32'd0);
      chk("reset_dbz", {31'd0, div_by_zero}, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);

      // Vector table.
      for (int i = 0; i < 10; i++) begin
         start_op(vecs[i].n, vecs[i].d, vecs[i].s);
         wait_done(dc, bc);
         $display("op %0d: %08h / %08h signed=%0d -> q=%08h r=%08h dbz=%0d done_cycle=%0d",
                  i, vecs[i].n, vecs[i].d, vecs[i].s, quotient, remainder, div_by_zero, dc);
         chk($sformatf("vec%0d_done_cycle", i), dc, vecs[i].cyc);
         chk($sformatf("vec%0d_busy_cycles", i), bc, vecs[i].cyc - 1);
         chk($sformatf("vec%0d_busy_at_done", i), {31'd0, busy}, 32'd0);
         chk($sformatf("vec%0d_quotient", i), quotient, vecs[i].q);
         chk($sformatf("vec%0d_remainder", i), remainder, vecs[i].r);
         chk($sformatf("vec%0d_dbz", i), {31'd0, div_by_zero}, {31'd0, vecs[i].z});
         @(negedge clk);
         chk($sformatf("vec%0d_done_pulse", i), {31'd0, done}, 32'd0);
      end

      // Start while busy is ignored; start in the DONE cycle is accepted.
      start_op(32'd50, 32'd5, 1'b0);
      dc = 0;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (done) begin
            dc = c;
            break;
         end
         if (c == 10) begin
            numer = 32'd9;
            denom = 32'd4;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      $display("op busy-start: 50/5 -> q=%0d r=%0d done_cycle=%0d", quotient, remainder, dc);
      chk("busystart_done_cycle", dc, 34);
      chk("busystart_quotient", quotient, 32'd10);
      chk("busystart_remainder", remainder, 32'd0);
      start_op(32'd9, 32'd4, 1'b0);
      wait_done(dc, bc);
      $display("op back-to-back: 9/4 -> q=%0d r=%0d done_cycle=%0d", quotient, remainder, dc);
      chk("b2b_done_cycle", dc, 34);
      chk("b2b_busy_cycles", bc, 33);
      chk("b2b_quotient", quotient, 32'd2);
      chk("b2b_remainder", remainder, 32'd1);
      @(negedge clk);

      // Flush in the middle of a calculation.
      start_op(32'd50, 32'd5, 1'b0);
      for (int c = 1; c <= 15; c++) @(negedge clk);
      chk("flush_busy_before", {31'd0, busy}, 32'd1);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      chk("flush_busy_after", {31'd0, busy}, 32'd0);
      done_seen = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      $display("op flush: 50/5 flushed at cycle 15 -> done_count=%0d q=%0d r=%0d", done_seen, quotient, remainder);
      chk("flush_no_done", done_seen, 0);
      chk("flush_quotient_kept", quotient, 32'd2);
      chk("flush_remainder_kept", remainder, 32'd1);
      chk("flush_dbz_kept", {31'd0, div_by_zero}, 32'd0);

      // Start together with flush is refused.
      numer = 32'd50;
      denom = 32'd5;
      start = 1'b1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      flush = 1'b0;
      @(negedge clk);
      $display("op start+flush: busy=%0d done=%0d", busy, done);
      chk("startflush_busy", {31'd0, busy}, 32'd0);
      chk("startflush_done", {31'd0, done}, 32'd0);

      // Asynchronous reset mid-operation.
      start_op(32'd50, 32'd5, 1'b0);
      for (int c = 1; c <= 20; c++) @(negedge clk);
      rst = 1'b1;
      #1;
      $display("op reset: async reset at cycle 20 -> busy=%0d q=%0d r=%0d", busy, quotient, remainder);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_done", {31'd0, done}, 32'd0);
      chk("arst_quotient", quotient, 32'd0);
      chk("arst_remainder", remainder, 32'd0);
      chk("arst_dbz", {31'd0, div_by_zero}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      done_seen = 0;
      busy_seen = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done) done_seen++;
         if (busy) busy_seen++;
      end
      chk("arst_no_done", done_seen, 0);
      chk("arst_no_busy", busy_seen, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
